// File: rtl/wpn_pkg.sv
// wpn_pkg
// Shared types and default constants for the weapon attack sequencer.
//   wpn_state_t : sequencer FSM states
//   wpn_mode_t  : weapon mode selected at attack start
//   DEF_*       : default frame counts / step sizes
//   max_offset  : peak offset magnitude for a frames/step pair
package wpn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXTEND   = 2'd1,
        ST_RETRACT  = 2'd2,
        ST_COOLDOWN = 2'd3
    } wpn_state_t;

    typedef enum logic {
        WPN_MELEE  = 1'b0,
        WPN_RANGED = 1'b1
    } wpn_mode_t;

    localparam int DEF_OFS_W           = 12;
    localparam int DEF_SWING_FRAMES    = 4;
    localparam int DEF_SWING_STEP      = 3;
    localparam int DEF_RECOIL_FRAMES   = 2;
    localparam int DEF_RECOIL_STEP     = 2;
    localparam int DEF_COOLDOWN_FRAMES = 3;
    localparam int FRAME_CNT_W         = 8;

    function automatic int max_offset(input int frames, input int step);
        return frames * step;
    endfunction

endpackage

// File: rtl/wpn_frame_cnt.sv
// wpn_frame_cnt
// Loadable frame-tick counter shared by the attack phases and the cooldown.
//   clk, rst   : clock, synchronous active-high reset
//   load       : clear the count to zero (wins over tick)
//   tick       : advance by one; the count saturates at limit
//   limit      : terminal count for the current phase (must be >= 1)
//   at_limit   : count has already reached limit
//   last_tick  : this tick is the one that brings the count to limit
module wpn_frame_cnt
    import wpn_pkg::*;
#(
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit,
    output logic             last_tick
);

    logic [CNT_W-1:0] count_reg;

    assign at_limit  = (count_reg == limit);
    assign last_tick = tick && (count_reg == (limit - CNT_W'(1)));

    // Saturating at the limit lets the cooldown phase remember that it has
    // expired while it waits for an outstanding projectile handshake.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count_reg <= '0;
        end else if (tick && !at_limit) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wpn_attack_seq.sv
// wpn_attack_seq
// Player weapon attack sequencer: melee swing or ranged shot with recoil,
// post-attack cooldown, one-deep click buffer, melee hit strobe and a
// valid/ready projectile spawn handshake.
//   clk, rst        : clock, synchronous active-high reset
//   frame_tick      : one-cycle pulse per video frame
//   mouse_clicked   : mouse button level
//   mode_sel        : 0 melee, 1 ranged (sampled at attack start)
//   pos_x           : player x
//   xpos_MouseCtl   : mouse x
//   anim_active     : high in EXTEND, RETRACT, COOLDOWN
//   facing_left     : facing latched at attack start
//   anim_x_offset   : signed weapon x displacement
//   hit_strobe      : one-clk pulse at the melee peak
//   fire_valid/ready: projectile spawn handshake, fire_dir 1 = left
//   cooldown_busy   : high in COOLDOWN
module wpn_attack_seq
    import wpn_pkg::*;
#(
    parameter int OFS_W           = DEF_OFS_W,
    parameter int SWING_FRAMES    = DEF_SWING_FRAMES,
    parameter int SWING_STEP      = DEF_SWING_STEP,
    parameter int RECOIL_FRAMES   = DEF_RECOIL_FRAMES,
    parameter int RECOIL_STEP     = DEF_RECOIL_STEP,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    mouse_clicked,
    input  logic                    mode_sel,
    input  logic [11:0]             pos_x,
    input  logic [11:0]             xpos_MouseCtl,
    output logic                    anim_active,
    output logic                    facing_left,
    output logic signed [OFS_W-1:0] anim_x_offset,
    output logic                    hit_strobe,
    output logic                    fire_valid,
    input  logic                    fire_ready,
    output logic                    fire_dir,
    output logic                    cooldown_busy
);

    // Peak offset must fit in the magnitude bits of the signed output.
    if (max_offset(SWING_FRAMES, SWING_STEP) >= (1 << (OFS_W - 1))) begin : g_swing_range
        $error("swing offset does not fit in OFS_W-1 bits");
    end
    if (max_offset(RECOIL_FRAMES, RECOIL_STEP) >= (1 << (OFS_W - 1))) begin : g_recoil_range
        $error("recoil offset does not fit in OFS_W-1 bits");
    end
    if (SWING_FRAMES < 1 || RECOIL_FRAMES < 1 || COOLDOWN_FRAMES < 1) begin : g_frames_min
        $error("frame counts must be at least 1");
    end

    localparam logic [FRAME_CNT_W-1:0] SWING_LIM    = FRAME_CNT_W'(SWING_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] RECOIL_LIM   = FRAME_CNT_W'(RECOIL_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOLDOWN_LIM = FRAME_CNT_W'(COOLDOWN_FRAMES);
    localparam logic signed [OFS_W-1:0] SWING_DELTA  = OFS_W'(SWING_STEP);
    localparam logic signed [OFS_W-1:0] RECOIL_DELTA = OFS_W'(RECOIL_STEP);

    wpn_state_t              state_reg,       state_next;
    wpn_mode_t               mode_reg,        mode_next;
    logic signed [OFS_W-1:0] offset_reg,      offset_next;
    logic                    facing_reg,      facing_next;
    logic                    hit_reg,         hit_next;
    logic                    fire_valid_reg,  fire_valid_next;
    logic                    fire_dir_reg,    fire_dir_next;
    logic                    pending_reg,     pending_next;
    logic                    click_reg;
    logic                    click_prev_reg;

    logic                    click_edge;
    logic                    start_attack;
    logic                    new_facing;
    logic                    cnt_load;
    logic                    cnt_at_limit;
    logic                    cnt_last_tick;
    logic [FRAME_CNT_W-1:0]  cnt_limit;
    logic signed [OFS_W-1:0] step_val;
    logic signed [OFS_W-1:0] delta;
    logic                    cooldown_expired;
    logic                    fire_clear;

    // Mouse level is registered first, then edge-detected against its own
    // delayed copy, so the edge is seen one clk after the level is captured.
    assign click_edge = click_reg & ~click_prev_reg;
    assign new_facing = (xpos_MouseCtl < pos_x);

    // Ranged recoil pushes the weapon away from the target, so its sign is
    // flipped relative to the melee swing.
    assign step_val = (mode_reg == WPN_RANGED) ? RECOIL_DELTA : SWING_DELTA;
    assign delta    = (facing_reg ^ (mode_reg == WPN_RANGED)) ? -step_val : step_val;

    assign cnt_limit = (state_reg == ST_COOLDOWN) ? COOLDOWN_LIM :
                       (mode_reg == WPN_RANGED)   ? RECOIL_LIM   : SWING_LIM;

    assign cooldown_expired = cnt_at_limit | cnt_last_tick;
    // Cooldown may only exit once no spawn request is outstanding; a request
    // being accepted this very clk counts as done.
    assign fire_clear = ~fire_valid_reg | fire_ready;

    wpn_frame_cnt #(
        .CNT_W (FRAME_CNT_W)
    ) u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .tick      (frame_tick && (state_reg != ST_IDLE)),
        .limit     (cnt_limit),
        .at_limit  (cnt_at_limit),
        .last_tick (cnt_last_tick)
    );

    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        offset_next     = offset_reg;
        facing_next     = facing_reg;
        hit_next        = 1'b0;
        fire_valid_next = fire_valid_reg;
        fire_dir_next   = fire_dir_reg;
        pending_next    = pending_reg;
        cnt_load        = 1'b0;
        start_attack    = 1'b0;

        if (fire_valid_reg && fire_ready) begin
            fire_valid_next = 1'b0;
        end

        // One-deep buffer: once pending, later edges have no further effect.
        if (click_edge && (state_reg != ST_IDLE)) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (click_edge) begin
                    start_attack = 1'b1;
                end
            end
            ST_EXTEND: begin
                if (frame_tick) begin
                    offset_next = offset_reg + delta;
                    if (cnt_last_tick) begin
                        state_next = ST_RETRACT;
                        cnt_load   = 1'b1;
                        hit_next   = (mode_reg == WPN_MELEE);
                    end
                end
            end
            ST_RETRACT: begin
                if (frame_tick) begin
                    offset_next = offset_reg - delta;
                    if (cnt_last_tick) begin
                        state_next = ST_COOLDOWN;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cooldown_expired && fire_clear) begin
                    // An edge arriving on the exit clk is honoured like a
                    // buffered click.
                    if (pending_reg || click_edge) begin
                        start_attack = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (start_attack) begin
            state_next  = ST_EXTEND;
            mode_next   = wpn_mode_t'(mode_sel);
            facing_next = new_facing;
            offset_next = '0;
            cnt_load    = 1'b1;
            if (mode_sel) begin
                fire_valid_next = 1'b1;
                fire_dir_next   = new_facing;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= WPN_MELEE;
            offset_reg     <= '0;
            facing_reg     <= 1'b0;
            hit_reg        <= 1'b0;
            fire_valid_reg <= 1'b0;
            fire_dir_reg   <= 1'b0;
            pending_reg    <= 1'b0;
            click_reg      <= 1'b0;
            click_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mode_reg       <= mode_next;
            offset_reg     <= offset_next;
            facing_reg     <= facing_next;
            hit_reg        <= hit_next;
            fire_valid_reg <= fire_valid_next;
            fire_dir_reg   <= fire_dir_next;
            pending_reg    <= pending_next;
            click_reg      <= mouse_clicked;
            click_prev_reg <= click_reg;
        end
    end

    assign anim_active   = (state_reg != ST_IDLE);
    assign cooldown_busy = (state_reg == ST_COOLDOWN);
    assign facing_left   = facing_reg;
    assign anim_x_offset = offset_reg;
    assign hit_strobe    = hit_reg;
    assign fire_valid    = fire_valid_reg;
    assign fire_dir      = fire_dir_reg;

endmodule
